// File: rtl/adder_seq_pkg.sv
// Shared definitions for the multi-cycle chunked adder/subtractor:
// the FSM state encoding and a constant-function log2 for sizing the chunk counter.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for values <= 1, so callers clamp to a minimum width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the caller can form signed overflow on the most-significant chunk.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the chunk ripple.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_seq_nb.sv
// Multi-cycle WIDTH-bit adder/subtractor working CHUNK bits per clock, LSB chunk first,
// with start/busy/done handshake. Define ADDER_SEQ_SAT_EN to saturate s on signed overflow.
module adder_seq_nb
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_params
        $error("adder_seq_nb: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_next, s_next;
    logic             carry_q;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
    logic             chunk_co, chunk_c_msb;
    logic             accept, last, ovf_next;

    // Only IDLE and DONE sample start; a start during RUN is dropped.
    assign accept    = start && (state_q != ST_RUN);
    assign last      = (state_q == ST_RUN) && (cnt_q == LAST);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        chunk_a  = a_q[int'(cnt_q)*CHUNK +: CHUNK];
        chunk_b  = b_q[int'(cnt_q)*CHUNK +: CHUNK];
        res_next = res_q;
        res_next[int'(cnt_q)*CHUNK +: CHUNK] = chunk_s;
        // Only meaningful in the last chunk, where these carries belong to bit WIDTH-1.
        ovf_next = chunk_co ^ chunk_c_msb;
`ifdef ADDER_SEQ_SAT_EN
        s_next = ovf_next ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : res_next;
`else
        s_next = res_next;
`endif
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (chunk_a),
        .b     (chunk_b),
        .ci    (carry_q),
        .s     (chunk_s),
        .co    (chunk_co),
        .c_msb (chunk_c_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s       <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub | ci;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            res_q   <= res_next;
            carry_q <= chunk_co;
            cnt_q   <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
                s   <= s_next;
                co  <= chunk_co;
                ovf <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_adder_seq_nb.sv
// Self-checking bench for adder_seq_nb at WIDTH=16, CHUNK=4 with a result scoreboard.
module tb_adder_seq_nb;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy, done, co, ovf;
    logic [W-1:0] s;
    logic [1:0]   dbg_state;

    // Scoreboard entry: {s, co, ovf}
    logic [W+1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    adder_seq_nb #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .co        (co),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mci, input logic msub);
        logic [W-1:0] bb;
        logic [W:0]   sum;
        logic         v;
        logic [W-1:0] r;
        bb  = msub ? ~mb : mb;
        sum = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mci)};
        r   = sum[W-1:0];
        v   = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
`ifdef ADDER_SEQ_SAT_EN
        if (v) r = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {r, sum[W], v};
    endfunction

    // Scoreboard monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                e = exp_q.pop_front();
                check("s", s, e[W+1:2]);
                check("co", co, e[1]);
                check("ovf", ovf, e[0]);
            end
        end
    end

    // Drives a one-cycle start pulse at a negedge and queues the expected result.
    task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                               input logic tsub, input bit push);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        ci    = tci;
        sub   = tsub;
        if (push) exp_q.push_back(model(ta, tb_, tci, tsub));
    endtask

    task automatic wait_done(output int cycles);
        bit seen;
        seen   = 0;
        cycles = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (start) start = 1'b0;
            if (done) seen = 1;
        end
        check("done_timeout", seen, 1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                          input logic tsub);
        int c;
        @(negedge clk);
        drive_start(ta, tb_, tci, tsub, 1);
        wait_done(c);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s", s, 0);
        check("rst_co", co, 0);
        check("rst_ovf", ovf, 0);

        // Exact latency and busy window
        @(negedge clk);
        drive_start(16'h00FF, 16'h0001, 0, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            check($sformatf("busy_c%0d", k), busy, (k <= 4) ? 1 : 0);
            check($sformatf("done_c%0d", k), done, (k == 5) ? 1 : 0);
        end
        @(negedge clk);
        check("done_pulse_len", done, 0);
        check("s_hold", s, 16'h0100);

        run_op(16'hFFFF, 16'h0001, 0, 0);
        run_op(16'h1234, 16'h1111, 1, 0);
        run_op(16'h7FFF, 16'h0001, 0, 0);
        run_op(16'h0005, 16'h0007, 0, 1);
        run_op(16'h8000, 16'h0001, 0, 1);
        run_op(16'h0005, 16'h0005, 1, 1);

        // start during RUN is ignored, operands sampled only on accept
        @(negedge clk);
        drive_start(16'h1111, 16'h2222, 0, 0, 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        drive_start(16'hAAAA, 16'h5555, 1, 1, 0);
        wait_done(c);
        check("run_start_latency", c, 3);
        repeat (8) @(negedge clk);
        check("sb_empty_ignore", exp_q.size(), 0);

        // Back-to-back: start in the DONE cycle
        @(negedge clk);
        drive_start(16'h0F0F, 16'h00F1, 0, 0, 1);
        wait_done(c);
        drive_start(16'h4000, 16'h4000, 0, 0, 1);
        wait_done(c);
        check("b2b_latency", c, 5);

        // Async reset mid-run
        run_op(16'hFFFF, 16'h8000, 0, 0);
        @(negedge clk);
        drive_start(16'h0101, 16'h0202, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_s", s, 0);
        check("arst_co", co, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_no_done", done, 0);
        run_op(16'h1234, 16'h4321, 0, 0);

        // Random operations
        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("sb_empty_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
